// File: rtl/bird_pkg.sv
// Shared bird-controller definitions: state codes, sprite geometry and colours,
// plus the datapath's internal sequencer encoding.
package bird_pkg;

  localparam logic [3:0] ST_HOLD    = 4'd0;
  localparam logic [3:0] ST_LEFT    = 4'd1;
  localparam logic [3:0] ST_RIGHT   = 4'd2;
  localparam logic [3:0] ST_UP      = 4'd3;
  localparam logic [3:0] ST_DOWN    = 4'd4;
  localparam logic [3:0] ST_CLEAR   = 4'd5;
  localparam logic [3:0] ST_DRAW    = 4'd6;
  localparam logic [3:0] ST_SHOT    = 4'd7;
  localparam logic [3:0] ST_ESCAPE  = 4'd8;
  localparam logic [3:0] ST_PREHOLD = 4'd9;

  localparam int         SPRITE_SIZE = 4;
  localparam logic [3:0] LAST_PIXEL  = 4'(SPRITE_SIZE * SPRITE_SIZE - 1);

  localparam logic [2:0] COLOUR_BIRD = 3'b110;
  localparam logic [2:0] COLOUR_BG   = 3'b000;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_SWEEP,
    SEQ_WAIT_TICK,
    SEQ_DONE
  } seq_state_t;

  function automatic logic is_sweep_code(input logic [3:0] s);
    return (s == ST_CLEAR) || (s == ST_DRAW) || (s == ST_SHOT) || (s == ST_ESCAPE);
  endfunction

endpackage

// File: rtl/bird_sprite_datapath_if.sv
// Controller <-> sprite datapath bundle, with the pixel-plot bus and a debug
// view of the datapath sequencer.
interface bird_sprite_datapath_if;
  import bird_pkg::*;

  // Handshake: the controller presents a state code and holds it; the datapath
  // answers with a single-cycle enable_draw when the requested sequence ends,
  // and accepts a new request only after state has left the code that started
  // the previous one. plot qualifies x_out/y_out/colour on every cycle.
  logic [3:0] state;
  logic       frame_tick;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic       enable_draw;
  logic       flying;
  seq_state_t seq_state;

  modport master (
    output state, frame_tick,
    input  x_out, y_out, colour, plot, enable_draw, flying, seq_state
  );

  modport slave (
    input  state, frame_tick,
    output x_out, y_out, colour, plot, enable_draw, flying, seq_state
  );

endinterface

// File: rtl/sprite_sweeper.sv
// Walks the 16 pixels of a 4x4 sprite row-major from a base position, one pixel
// per cycle; done_o is high while the last pixel is on the outputs.
module sprite_sweeper
  import bird_pkg::*;
#(
  parameter logic [2:0] IDLE_COLOUR = COLOUR_BG
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_i,
  input  logic [2:0] colour_i,
  input  logic [7:0] base_x_i,
  input  logic [6:0] base_y_i,
  output logic       plot_o,
  output logic [7:0] x_o,
  output logic [6:0] y_o,
  output logic [2:0] colour_o,
  output logic       done_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_inc;
  logic       plot_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;

  assign cnt_inc = cnt_q + 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= 4'd0;
      plot_q   <= 1'b0;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      colour_q <= IDLE_COLOUR;
    end else if (start_i) begin
      cnt_q    <= 4'd0;
      plot_q   <= 1'b1;
      x_q      <= base_x_i;
      y_q      <= base_y_i;
      colour_q <= colour_i;
    end else if (plot_q) begin
      if (cnt_q == LAST_PIXEL) begin
        cnt_q  <= 4'd0;
        plot_q <= 1'b0;
      end else begin
        // column in the low bits, row in the high bits
        cnt_q <= cnt_inc;
        x_q   <= base_x_i + {6'd0, cnt_inc[1:0]};
        y_q   <= base_y_i + {5'd0, cnt_inc[3:2]};
      end
    end
  end

  assign plot_o   = plot_q;
  assign x_o      = x_q;
  assign y_o      = y_q;
  assign colour_o = colour_q;
  assign done_o   = plot_q && (cnt_q == LAST_PIXEL);

endmodule

// File: rtl/bird_sprite_datapath.sv
// Bird position register plus draw/erase/fall sequencing for the 4x4 bird sprite.
// Define BIRD_EDGE_WRAP_EN to wrap moves at the screen edges instead of saturating.
module bird_sprite_datapath
  import bird_pkg::*;
#(
  parameter logic [7:0] X_SPAWN     = 8'd76,
  parameter logic [6:0] Y_SPAWN     = 7'd100,
  parameter logic [7:0] X_MAX       = 8'd156,
  parameter logic [6:0] Y_MAX       = 7'd116,
  parameter logic [2:0] BIRD_COLOUR = COLOUR_BIRD,
  parameter logic [2:0] BG_COLOUR   = COLOUR_BG
) (
  input  logic                   clk,
  input  logic                   reset_n,
  bird_sprite_datapath_if.slave  bus
);

  seq_state_t seq_q;
  logic [7:0] bird_x_q;
  logic [6:0] bird_y_q;
  logic       flying_q;
  logic       enable_draw_q;
  logic [3:0] mode_q;
  logic [3:0] block_code_q;
  logic       block_q;
  logic       erase_q;
  logic       relaunch_q;

  logic       start;
  logic [2:0] sweep_colour;
  logic       sweep_last;
  logic       sw_plot;
  logic [7:0] sw_x;
  logic [6:0] sw_y;
  logic [2:0] sw_colour;
  logic       trig_ok;
  logic       fall_mode;
  logic       at_end;
  logic [6:0] fall_y;

  function automatic logic [7:0] step_x(input logic [7:0] v, input logic inc);
    logic [7:0] r;
`ifdef BIRD_EDGE_WRAP_EN
    if (inc) r = (v >= X_MAX) ? 8'd0 : v + 8'd1;
    else     r = (v == 8'd0) ? X_MAX : v - 8'd1;
`else
    if (inc) r = (v >= X_MAX) ? X_MAX : v + 8'd1;
    else     r = (v == 8'd0) ? 8'd0 : v - 8'd1;
`endif
    return r;
  endfunction

  function automatic logic [6:0] step_y(input logic [6:0] v, input logic inc);
    logic [6:0] r;
`ifdef BIRD_EDGE_WRAP_EN
    if (inc) r = (v >= Y_MAX) ? 7'd0 : v + 7'd1;
    else     r = (v == 7'd0) ? Y_MAX : v - 7'd1;
`else
    if (inc) r = (v >= Y_MAX) ? Y_MAX : v + 7'd1;
    else     r = (v == 7'd0) ? 7'd0 : v - 7'd1;
`endif
    return r;
  endfunction

  // A finished request stays blocked until the controller moves off its code.
  assign trig_ok   = is_sweep_code(bus.state) && !(block_q && (bus.state == block_code_q));
  assign fall_mode = (mode_q == ST_SHOT) || (mode_q == ST_ESCAPE);
  assign at_end    = (mode_q == ST_SHOT) ? (bird_y_q == Y_MAX) : (bird_y_q == 7'd0);
  assign fall_y    = step_y(bird_y_q, mode_q == ST_SHOT);

  always_comb begin
    start        = 1'b0;
    sweep_colour = BIRD_COLOUR;
    case (seq_q)
      SEQ_IDLE: begin
        if (trig_ok) begin
          start        = 1'b1;
          sweep_colour = (bus.state == ST_CLEAR) ? BG_COLOUR : BIRD_COLOUR;
        end
      end
      SEQ_SWEEP: begin
        start = relaunch_q;
      end
      SEQ_WAIT_TICK: begin
        if (bus.frame_tick && fall_mode) begin
          start        = 1'b1;
          sweep_colour = BG_COLOUR;
        end
      end
      default: ;
    endcase
  end

  sprite_sweeper #(
    .IDLE_COLOUR (BG_COLOUR)
  ) u_sweeper (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (start),
    .colour_i (sweep_colour),
    .base_x_i (bird_x_q),
    .base_y_i (bird_y_q),
    .plot_o   (sw_plot),
    .x_o      (sw_x),
    .y_o      (sw_y),
    .colour_o (sw_colour),
    .done_o   (sweep_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_q         <= SEQ_IDLE;
      bird_x_q      <= X_SPAWN;
      bird_y_q      <= Y_SPAWN;
      flying_q      <= 1'b1;
      enable_draw_q <= 1'b0;
      mode_q        <= ST_HOLD;
      block_code_q  <= ST_HOLD;
      block_q       <= 1'b0;
      erase_q       <= 1'b0;
      relaunch_q    <= 1'b0;
    end else begin
      enable_draw_q <= 1'b0;
      if (block_q && (bus.state != block_code_q)) block_q <= 1'b0;

      // The position is frozen while pixels are being plotted.
      if (seq_q != SEQ_SWEEP) begin
        case (bus.state)
          ST_LEFT:  bird_x_q <= step_x(bird_x_q, 1'b0);
          ST_RIGHT: bird_x_q <= step_x(bird_x_q, 1'b1);
          ST_UP:    bird_y_q <= step_y(bird_y_q, 1'b0);
          ST_DOWN:  bird_y_q <= step_y(bird_y_q, 1'b1);
          ST_PREHOLD: begin
            bird_x_q <= X_SPAWN;
            bird_y_q <= Y_SPAWN;
            flying_q <= 1'b1;
          end
          default: ;
        endcase
      end

      case (seq_q)
        SEQ_IDLE: begin
          if (trig_ok) begin
            seq_q        <= SEQ_SWEEP;
            mode_q       <= bus.state;
            erase_q      <= 1'b0;
            block_q      <= 1'b1;
            block_code_q <= bus.state;
          end
        end
        SEQ_SWEEP: begin
          if (relaunch_q) begin
            relaunch_q <= 1'b0;
          end else if (sweep_last) begin
            if (mode_q == ST_CLEAR) begin
              seq_q <= SEQ_WAIT_TICK;
            end else if (mode_q == ST_DRAW) begin
              seq_q         <= SEQ_DONE;
              enable_draw_q <= 1'b1;
            end else if (erase_q) begin
              // Old sprite erased: step one row, then redraw next cycle.
              erase_q    <= 1'b0;
              relaunch_q <= 1'b1;
              bird_y_q   <= fall_y;
            end else if (at_end) begin
              flying_q      <= 1'b0;
              seq_q         <= SEQ_DONE;
              enable_draw_q <= 1'b1;
            end else begin
              seq_q <= SEQ_WAIT_TICK;
            end
          end
        end
        SEQ_WAIT_TICK: begin
          if (bus.frame_tick) begin
            if (fall_mode) begin
              seq_q   <= SEQ_SWEEP;
              erase_q <= 1'b1;
            end else begin
              seq_q         <= SEQ_DONE;
              enable_draw_q <= 1'b1;
            end
          end
        end
        SEQ_DONE: begin
          seq_q <= SEQ_IDLE;
        end
        default: seq_q <= SEQ_IDLE;
      endcase
    end
  end

  assign bus.plot        = sw_plot;
  assign bus.x_out       = sw_x;
  assign bus.y_out       = sw_y;
  assign bus.colour      = sw_colour;
  assign bus.enable_draw = enable_draw_q;
  assign bus.flying      = flying_q;
  assign bus.seq_state   = seq_q;

endmodule
